// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared comparator result encoding and sample decode helpers
//
// Package cmp_pkg
//   cmp_state_t      : committed comparator result (UNK=0, EQ=1, GT=2, LT=3)
//   CMP_RUN_W        : width of the debounce run counter (covers DEBOUNCE 1..15)
//   cmp_decode()     : priority decode of the three flags (gt > lt > eq, none -> EQ)
//   cmp_onehot()     : true when exactly one flag is high
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_UNK = 2'd0,
    CMP_EQ  = 2'd1,
    CMP_GT  = 2'd2,
    CMP_LT  = 2'd3
  } cmp_state_t;

  localparam int CMP_RUN_W = 4;

  // For a one-hot sample this is the exact class; for anything else it
  // resolves by priority so the default build always yields a usable class.
  function automatic cmp_state_t cmp_decode(input logic gt, input logic lt, input logic eq);
    cmp_state_t cls;
    if (gt)      cls = CMP_GT;
    else if (lt) cls = CMP_LT;
    else         cls = CMP_EQ;
    if (eq && !gt && !lt) cls = CMP_EQ;
    return cls;
  endfunction

  function automatic logic cmp_onehot(input logic gt, input logic lt, input logic eq);
    return (gt ^ lt ^ eq) && !(gt && lt && eq);
  endfunction

endpackage

// File: rtl/cmp_debounce.sv
// rtl/cmp_debounce.sv - candidate/run tracker that emits a one-cycle commit pulse
//
// Optional feature macro: CMP_MON_ONEHOT_CHECK_EN (reject non-one-hot samples)
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid              : flags valid this cycle
//   a_gt_b/a_lt_b/a_eq_b  : comparator flags
//   state                 : currently committed result (from the top)
//   commit                : combinational pulse, committing commit_class on this edge
//   commit_class          : class being committed
//   bad_sample            : combinational pulse, non-one-hot valid sample rejected
module cmp_debounce
  import cmp_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       a_gt_b,
  input  logic       a_lt_b,
  input  logic       a_eq_b,
  input  cmp_state_t state,
  output logic       commit,
  output cmp_state_t commit_class,
  output logic       bad_sample
);

  localparam logic [CMP_RUN_W-1:0] RUN_MAX = CMP_RUN_W'(DEBOUNCE);

  cmp_state_t           cand;
  cmp_state_t           cand_next;
  cmp_state_t           sample_class;
  logic [CMP_RUN_W-1:0] run;
  logic [CMP_RUN_W-1:0] run_next;
  logic                 sample_ok;

  always_comb begin
    sample_class = cmp_decode(a_gt_b, a_lt_b, a_eq_b);
`ifdef CMP_MON_ONEHOT_CHECK_EN
    sample_ok    = cmp_onehot(a_gt_b, a_lt_b, a_eq_b);
`else
    sample_ok    = 1'b1;
`endif
    cand_next  = cand;
    run_next   = run;
    bad_sample = 1'b0;
    if (in_valid) begin
      if (!sample_ok) begin
        cand_next  = CMP_UNK;
        run_next   = '0;
        bad_sample = 1'b1;
      end else if (sample_class == cand) begin
        if (run < RUN_MAX) run_next = run + 1'b1;
      end else begin
        cand_next = sample_class;
        run_next  = CMP_RUN_W'(1);
      end
    end
    // A saturated run on the already-committed class never re-commits
    // because the candidate then equals state.
    commit       = in_valid && sample_ok && (run_next == RUN_MAX) && (cand_next != state);
    commit_class = cand_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= CMP_UNK;
      run  <= '0;
    end else begin
      cand <= cand_next;
      run  <= run_next;
    end
  end

endmodule

// File: rtl/cmp_result_monitor.sv
// rtl/cmp_result_monitor.sv - debounced comparator result monitor with change events
//
// Optional feature macro: CMP_MON_ONEHOT_CHECK_EN (err flags non-one-hot samples)
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid              : flags valid this cycle
//   a_gt_b/a_lt_b/a_eq_b  : comparator flags
//   clr                   : synchronous clear of evt_cnt, ovf, err
//   state                 : committed result
//   evt_valid/evt_ready   : change event handshake
//   evt_from/evt_to       : previous and new committed result of the pending event
//   evt_cnt               : committed changes, wraps
//   ovf                   : sticky, a commit was merged into a pending event
//   err                   : sticky, a non-one-hot sample was seen (feature build only)
module cmp_result_monitor
  import cmp_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  input  logic             clr,
  output cmp_state_t       state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output cmp_state_t       evt_from,
  output cmp_state_t       evt_to,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf,
  output logic             err
);

  logic       commit;
  logic       bad_sample;
  logic       coalesce;
  cmp_state_t commit_class;

  cmp_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .a_gt_b       (a_gt_b),
    .a_lt_b       (a_lt_b),
    .a_eq_b       (a_eq_b),
    .state        (state),
    .commit       (commit),
    .commit_class (commit_class),
    .bad_sample   (bad_sample)
  );

  // An event still waiting (not accepted this cycle) absorbs the new commit.
  assign coalesce = commit && evt_valid && !evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CMP_UNK;
      evt_valid <= 1'b0;
      evt_from  <= CMP_UNK;
      evt_to    <= CMP_UNK;
    end else begin
      if (commit) begin
        state <= commit_class;
        if (coalesce) begin
          evt_to <= commit_class;
        end else begin
          evt_from  <= state;
          evt_to    <= commit_class;
          evt_valid <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

  // bad_sample is constant low unless the one-hot check is built in, so err
  // stays at zero in the default build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      evt_cnt <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (commit)     evt_cnt <= evt_cnt + CNT_W'(1);
      if (coalesce)   ovf     <= 1'b1;
      if (bad_sample) err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb/tb_cmp_result_monitor.sv - self-checking bench for cmp_result_monitor
module tb_cmp_result_monitor;
  import cmp_pkg::*;

  localparam int DEB   = 3;
  localparam int CNT_W = 4;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_EQ = 3'b001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             a_gt_b = 1'b0;
  logic             a_lt_b = 1'b0;
  logic             a_eq_b = 1'b0;
  logic             clr = 1'b0;
  logic             evt_ready = 1'b0;
  cmp_state_t       state;
  cmp_state_t       evt_from;
  cmp_state_t       evt_to;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_cnt;
  logic             ovf;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: history of the most recent valid sample classes.
  logic [1:0] m_hist[$];
  logic [1:0] m_state, m_from, m_to;
  logic       m_evt_valid, m_ovf, m_err;
  int         m_cnt;

  always #5 clk = ~clk;

  cmp_result_monitor #(
    .DEBOUNCE (DEB),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .a_eq_b    (a_eq_b),
    .clr       (clr),
    .state     (state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_from  (evt_from),
    .evt_to    (evt_to),
    .evt_cnt   (evt_cnt),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_class(input logic [2:0] f);
    if (f[2]) return 2'd2;
    if (f[1]) return 2'd3;
    return 2'd1;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_state = 2'd0; m_from = 2'd0; m_to = 2'd0;
    m_evt_valid = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  // One clock edge of the specification's behaviour: a commit happens when the
  // last DEB valid samples all agree and differ from the committed result.
  task automatic model_edge(input logic v, input logic [2:0] f, input logic rdy, input logic c);
    logic       ok;
    logic       do_commit;
    logic       hs;
    logic [1:0] cls;
    do_commit = 1'b0;
    cls       = ref_class(f);
    hs        = m_evt_valid && rdy;
    if (v) begin
      ok = 1'b1;
`ifdef CMP_MON_ONEHOT_CHECK_EN
      ok = ($countones(f) == 1);
`endif
      if (!ok) begin
        m_hist.delete();
        m_err = 1'b1;
      end else begin
        m_hist.push_back(cls);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB && cls != m_state) begin
          do_commit = 1'b1;
          foreach (m_hist[i]) if (m_hist[i] != cls) do_commit = 1'b0;
        end
      end
    end
    if (do_commit) begin
      m_cnt++;
      if (m_evt_valid && !hs) begin
        m_to  = cls;
        m_ovf = 1'b1;
      end else begin
        m_from      = m_state;
        m_to        = cls;
        m_evt_valid = 1'b1;
      end
      m_state = cls;
    end else if (hs) begin
      m_evt_valid = 1'b0;
    end
    if (c) begin
      m_cnt = 0; m_ovf = 1'b0; m_err = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_state));
    chk("evt_valid", 32'(evt_valid), 32'(m_evt_valid));
    if (m_evt_valid) begin
      chk("evt_from", 32'(evt_from), 32'(m_from));
      chk("evt_to", 32'(evt_to), 32'(m_to));
    end
    chk("evt_cnt", 32'(evt_cnt), 32'(m_cnt % (1 << CNT_W)));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next fall.
  task automatic step(input logic v, input logic [2:0] f, input logic rdy, input logic c);
    in_valid = v; {a_gt_b, a_lt_b, a_eq_b} = f; evt_ready = rdy; clr = c;
    @(posedge clk);
    model_edge(v, f, rdy, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic rep(input int n, input logic [2:0] f, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, f, rdy, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_from", 32'(evt_from), 32'd0);
    chk("rst_evt_to", 32'(evt_to), 32'd0);
    chk("rst_evt_cnt", 32'(evt_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] f;
    model_reset();
    @(negedge clk);
    async_reset();

    // Three agreeing GT samples commit from UNK.
    step(1'b1, F_GT, 1'b1, 1'b0);
    step(1'b1, F_GT, 1'b1, 1'b0);
    chk("gt3_early_valid", 32'(evt_valid), 32'd0);
    step(1'b1, F_GT, 1'b1, 1'b0);
    chk("gt3_valid", 32'(evt_valid), 32'd1);
    chk("gt3_from", 32'(evt_from), 32'd0);
    chk("gt3_to", 32'(evt_to), 32'd2);
    chk("gt3_cnt", 32'(evt_cnt), 32'd1);

    // An interrupting LT restarts the run; only the sixth sample commits.
    async_reset();
    rep(1, F_GT, 1'b1); rep(1, F_GT, 1'b1); rep(1, F_LT, 1'b1);
    rep(1, F_GT, 1'b1); rep(1, F_GT, 1'b1);
    chk("restart_cnt5", 32'(evt_cnt), 32'd0);
    step(1'b0, F_LT, 1'b1, 1'b0);
    chk("gap_cnt", 32'(evt_cnt), 32'd0);
    rep(1, F_GT, 1'b1);
    chk("restart_cnt6", 32'(evt_cnt), 32'd1);
    chk("restart_to", 32'(evt_to), 32'd2);

    // Coalescing while downstream stalls.
    async_reset();
    rep(3, F_EQ, 1'b0);
    rep(3, F_GT, 1'b0);
    chk("coal_from", 32'(evt_from), 32'd0);
    chk("coal_to", 32'(evt_to), 32'd2);
    chk("coal_ovf", 32'(ovf), 32'd1);
    chk("coal_cnt", 32'(evt_cnt), 32'd2);
    step(1'b0, 3'b000, 1'b1, 1'b0);
    chk("coal_drain", 32'(evt_valid), 32'd0);

    // Commit in the same cycle as the accepting handshake.
    async_reset();
    rep(3, F_EQ, 1'b0);
    rep(2, F_GT, 1'b0);
    rep(1, F_GT, 1'b1);
    chk("hs_valid", 32'(evt_valid), 32'd1);
    chk("hs_from", 32'(evt_from), 32'd1);
    chk("hs_to", 32'(evt_to), 32'd2);
    chk("hs_ovf", 32'(ovf), 32'd0);

    // Non-one-hot flags, then clear (clear also races a commit here).
    async_reset();
    rep(3, F_EQ, 1'b0);
    rep(3, F_LT, 1'b0);
    rep(3, 3'b110, 1'b0);
`ifdef CMP_MON_ONEHOT_CHECK_EN
    chk("nonhot_err", 32'(err), 32'd1);
    chk("nonhot_state", 32'(state), 32'd3);
    chk("nonhot_cnt", 32'(evt_cnt), 32'd2);
`else
    chk("nonhot_err", 32'(err), 32'd0);
    chk("nonhot_state", 32'(state), 32'd2);
    chk("nonhot_cnt", 32'(evt_cnt), 32'd3);
`endif
    step(1'b0, 3'b000, 1'b0, 1'b1);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_cnt", 32'(evt_cnt), 32'd0);
    rep(2, F_EQ, 1'b0);
    step(1'b1, F_EQ, 1'b0, 1'b1);
    chk("clr_wins_cnt", 32'(evt_cnt), 32'd0);
    chk("clr_wins_ovf", 32'(ovf), 32'd0);

    // Reset mid-debounce with an event pending.
    async_reset();
    rep(3, F_EQ, 1'b0);
    rep(2, F_GT, 1'b0);
    async_reset();
    rep(3, F_LT, 1'b1);
    chk("post_rst_from", 32'(evt_from), 32'd0);
    chk("post_rst_to", 32'(evt_to), 32'd3);
    chk("post_rst_cnt", 32'(evt_cnt), 32'd1);

    // Randomized traffic against the model.
    f = F_GT;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(9) >= 7) f = 3'($urandom_range(7));
        step($urandom_range(9) < 8, f, 1'($urandom_range(1)), $urandom_range(59) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_result_monitor.md
CMP_RESULT_MONITOR -- requirements
Module: cmp_result_monitor

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive identical valid samples required to commit a new result; legal range 1..15.
REQ-002 Parameter CNT_W, default 8: width of the committed-event counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  comparator flags are valid this cycle.
REQ-006 a_gt_b / a_lt_b / a_eq_b  in  1 each  flags from the upstream 4-bit magnitude comparator.
REQ-007 clr  in  1  synchronous clear of evt_cnt, ovf and err.
REQ-008 state  out  2  committed result (cmp_state_t).
REQ-009 evt_valid  out  1  result-change event pending.
REQ-010 evt_ready  in  1  downstream accepts event.
REQ-011 evt_from / evt_to  out  2 each  previous and new committed result.
REQ-012 evt_cnt  out  CNT_W  number of committed changes, wraps modulo 2^CNT_W.
REQ-013 ovf  out  1  sticky: event coalesced while pending.
REQ-014 err  out  1  sticky: non-one-hot flags sampled (CMP_MON_ONEHOT_CHECK_EN only).

Function
REQ-015 Encoding SHALL be UNK=0, EQ=1, GT=2, LT=3; UNK exists only after reset.
REQ-016 Sample decode SHALL be: exactly one flag high -> corresponding class.
REQ-017 On in_valid with class equal to candidate, run SHALL increment, saturating at DEBOUNCE; else candidate <= class, run <= 1.
REQ-018 Cycles with in_valid low SHALL leave candidate and run unchanged (gaps tolerated).
REQ-019 Commit SHALL occur in the cycle the updated run equals DEBOUNCE and candidate differs from state; state, evt_* and evt_cnt update on that edge (visible next cycle).
REQ-020 Run already saturated with candidate equal to state SHALL produce no event.
REQ-021 Event handshake: evt_valid held until evt_valid && evt_ready; evt_from/evt_to stable while pending.
REQ-022 Commit while event pending and evt_ready low: evt_to <= new state, evt_from retained, ovf <= 1, evt_valid stays 1.
REQ-023 Commit in same cycle as accepted handshake: new event loaded, evt_valid stays 1, no ovf.
REQ-024 Commit back to evt_from while coalescing SHALL still be reported (evt_from == evt_to allowed).
REQ-025 evt_cnt SHALL increment on every commit, including coalesced ones.
REQ-026 clr SHALL zero evt_cnt, ovf, err; clr wins over a same-cycle set or increment.
REQ-027 DEBOUNCE=1 SHALL commit on the first differing valid sample.

Reset
REQ-028 rst_n low SHALL immediately force state=UNK, candidate=UNK, run=0, evt_valid=0, evt_from=evt_to=UNK, evt_cnt=0, ovf=0, err=0; a pending event is discarded.
REQ-029 First commit after reset SHALL report evt_from=UNK.

Configuration
REQ-030 Macro CMP_MON_ONEHOT_CHECK_EN defined: non-one-hot valid sample discarded, candidate <= UNK, run <= 0, err <= 1.
REQ-031 Macro undefined: priority decode gt > lt > eq, all-zero decodes EQ, err tied 0.

Structure
REQ-032 Package cmp_pkg SHALL hold cmp_state_t and the encoding constants; shared with downstream consumers.
REQ-033 Sub-module cmp_debounce (candidate/run logic, outputs commit pulse and class) SHALL be used; event register and counters stay in top.

Verification
REQ-034 DEBOUNCE=3: GT,GT,GT valid, evt_ready=1 -> evt_valid one cycle after third sample, from=UNK, to=GT, evt_cnt=1.
REQ-035 GT,GT,LT,GT,GT,GT -> single commit after sixth sample only; no commit at LT.
REQ-036 evt_ready=0; commit EQ then GT -> evt_from=UNK, evt_to=GT, ovf=1, evt_cnt=2; raise evt_ready -> evt_valid drops.
REQ-037 Pending event with evt_ready=1 and new commit same cycle -> evt_valid stays 1, new values, ovf=0.
REQ-038 Flags 3'b110 valid: with macro err=1 and run reset; without, class GT; then clr -> err=0, ovf=0, evt_cnt=0.
REQ-039 rst_n asserted mid-debounce and with event pending -> all outputs reset values asynchronously; next commit from=UNK.
